display_digit_decoder: RTL and testbench

Downstream consumer of the 8-digit scan controller's `anode`/`seg_sel` outputs. It holds a 32-bit display value with tear-free double buffering. For each scan slot it selects the 4-bit nibble indexed by `seg_sel`, applies optional leading-zero blanking, and hex-decodes the nibble to 7-segment cathodes. Cathodes, decimal point and a re-timed anode vector are registered together, so the anode and its cathodes change on the same edge and no ghosting occurs.

---
 rtl/display_digit_decoder.sv | 134 +++++++++++++
 tb/tb_display_digit_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/display_digit_decoder.sv
// display_digit_decoder
// Takes the scan controller's digit index and anode vector and produces the
// matching 7-segment cathodes, decimal point and a re-timed anode vector.
// The displayed value is double buffered: new data lands in a staging
// register and is copied to the display register only at the start of a
// scan frame (seg_sel == 0), so a frame never shows a mix of two values.
// Cathodes, dp and anode_out are registered on the same edge so a digit's
// anode and its cathodes always switch together.

module display_digit_decoder #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] seg_sel,
  input  logic [7:0] anode_in,
  input  logic [31:0] data_in,
  input  logic       load,
  input  logic [7:0] dp_en,
  input  logic       blank_lz,
  output logic       pending,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] anode_out
);

  // Board-level polarity: active-high outputs are the bitwise inverse of the
  // active-low form computed internally.
  localparam logic       INVERT    = (ACTIVE_LOW == 0);
  localparam logic [6:0] SEG_OFF   = INVERT ? 7'h00 : 7'h7F;
  localparam logic       DP_OFF    = INVERT ? 1'b0  : 1'b1;
  localparam logic [7:0] ANODE_OFF = INVERT ? 8'h00 : 8'hFF;

  // Active-low hex decode, seg[6:0] = {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Applies output polarity to a cathode vector.
  function automatic logic [6:0] pol_seg(input logic [6:0] s);
    return INVERT ? ~s : s;
  endfunction

  logic [31:0] staging_r;
  logic [31:0] display_r;
  logic        pending_r;

  logic [3:0]  nib_p0;
  logic [7:0]  zero_above_p0;
  logic        blank_p0;
  logic [6:0]  seg_p0;
  logic        dp_p0;
  logic [7:0]  anode_p0;

  logic [6:0]  seg_p1;
  logic        dp_p1;
  logic [7:0]  anode_p1;

  // Double buffer: load always wins; otherwise commit at frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_r <= '0;
      display_r <= '0;
      pending_r <= 1'b0;
    end else if (load) begin
      staging_r <= data_in;
      pending_r <= 1'b1;
    end else if (seg_sel == 3'd0 && pending_r) begin
      display_r <= staging_r;
      pending_r <= 1'b0;
    end
  end

  // ---- stage p0: nibble select, leading-zero detect, decode ----

  // zero_above_p0[k] is set when display nibbles k..7 are all zero.
  always_comb begin
    zero_above_p0    = '0;
    zero_above_p0[7] = (display_r[31:28] == 4'h0);
    for (int k = 6; k >= 0; k--) begin
      zero_above_p0[k] = zero_above_p0[k+1] && (display_r[4*k +: 4] == 4'h0);
    end
  end

  // Select the scanned digit, blank it if it is a leading zero, and form
  // polarity-corrected outputs ready for the output register.
  always_comb begin
    nib_p0   = display_r[{seg_sel, 2'b00} +: 4];
    blank_p0 = blank_lz && (seg_sel != 3'd0) && zero_above_p0[seg_sel];
    seg_p0   = pol_seg(blank_p0 ? 7'b1111111 : hex_to_seg(nib_p0));
    dp_p0    = INVERT ? dp_en[seg_sel] : ~dp_en[seg_sel];
    anode_p0 = INVERT ? ~anode_in : anode_in;
  end

  // ---- stage p1: cathodes, dp and anodes registered together ----

  // Output register; reset drives every digit and segment off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_p1   <= SEG_OFF;
      dp_p1    <= DP_OFF;
      anode_p1 <= ANODE_OFF;
    end else begin
      seg_p1   <= seg_p0;
      dp_p1    <= dp_p0;
      anode_p1 <= anode_p0;
    end
  end

  assign pending   = pending_r;
  assign seg       = seg_p1;
  assign dp        = dp_p1;
  assign anode_out = anode_p1;

endmodule

// File: tb/tb_display_digit_decoder.sv
// Directed bench for display_digit_decoder. Two instances share stimulus:
// dut_l uses active-low outputs, dut_h active-high outputs.

module tb_display_digit_decoder;

  logic        clk;
  logic        reset;
  logic [2:0]  seg_sel;
  logic [7:0]  anode_in;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_en;
  logic        blank_lz;

  logic        pending_l, dp_l;
  logic [6:0]  seg_l;
  logic [7:0]  anode_out_l;
  logic        pending_h, dp_h;
  logic [6:0]  seg_h;
  logic [7:0]  anode_out_h;

  int errors = 0;
  int checks = 0;

  display_digit_decoder #(.ACTIVE_LOW(1)) dut_l (
    .clk(clk), .reset(reset), .seg_sel(seg_sel), .anode_in(anode_in),
    .data_in(data_in), .load(load), .dp_en(dp_en), .blank_lz(blank_lz),
    .pending(pending_l), .seg(seg_l), .dp(dp_l), .anode_out(anode_out_l)
  );

  display_digit_decoder #(.ACTIVE_LOW(0)) dut_h (
    .clk(clk), .reset(reset), .seg_sel(seg_sel), .anode_in(anode_in),
    .data_in(data_in), .load(load), .dp_en(dp_en), .blank_lz(blank_lz),
    .pending(pending_h), .seg(seg_h), .dp(dp_h), .anode_out(anode_out_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One scan slot: present sel/anode (and optional load), clock once,
  // leave outputs settled 1 time unit after the edge.
  task automatic drive(input logic [2:0] sel, input logic ld, input logic [31:0] d);
    seg_sel  = sel;
    anode_in = ~(8'h01 << sel);
    load     = ld;
    data_in  = d;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (seg_l !== 7'b1111111) begin errors++; $display("FAIL reset_seg actual=%b required=%b", seg_l, 7'b1111111); end
    checks++;
    if (dp_l !== 1'b1) begin errors++; $display("FAIL reset_dp actual=%b required=1", dp_l); end
    checks++;
    if (anode_out_l !== 8'hFF) begin errors++; $display("FAIL reset_anode actual=%h required=ff", anode_out_l); end
    checks++;
    if (pending_l !== 1'b0) begin errors++; $display("FAIL reset_pending actual=%b required=0", pending_l); end
    checks++;
    if ({seg_h, dp_h, anode_out_h} !== 16'h0000) begin
      errors++; $display("FAIL reset_high actual=%h required=0000", {seg_h, dp_h, anode_out_h});
    end
  endtask

  task automatic test_scan_zero();
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 8; s++) begin
      drive(3'(s), 1'b0, 32'h0);
      checks++;
      if (seg_l !== 7'b0000001 || dp_l !== 1'b1) begin
        errors++; $display("FAIL scan0_seg sel=%0d actual=%b/%b required=0000001/1", s, seg_l, dp_l);
      end
      checks++;
      if (anode_out_l !== ~(8'h01 << s)) begin
        errors++; $display("FAIL scan0_anode sel=%0d actual=%h required=%h", s, anode_out_l, ~(8'h01 << s));
      end
    end
  endtask

  task automatic test_async_reset();
    drive(3'd3, 1'b1, 32'h12345678);
    drive(3'd0, 1'b0, 32'h0);
    drive(3'd1, 1'b0, 32'h0);
    checks++;
    if (seg_l !== 7'b0001111) begin errors++; $display("FAIL pre_reset_seg actual=%b required=0001111", seg_l); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (seg_l !== 7'b1111111 || dp_l !== 1'b1 || anode_out_l !== 8'hFF) begin
      errors++; $display("FAIL async_reset actual=%b/%b/%h required=1111111/1/ff", seg_l, dp_l, anode_out_l);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(3'd4, 1'b0, 32'h0);
    checks++;
    if (seg_l !== 7'b0000001) begin errors++; $display("FAIL post_reset_seg actual=%b required=0000001", seg_l); end
  endtask

  task automatic test_commit();
    drive(3'd5, 1'b1, 32'hDEADBEEF);
    checks++;
    if (pending_l !== 1'b1 || seg_l !== 7'b0000001) begin
      errors++; $display("FAIL commit_load actual=%b/%b required=1/0000001", pending_l, seg_l);
    end
    drive(3'd6, 1'b0, 32'h0);
    checks++;
    if (seg_l !== 7'b0000001) begin errors++; $display("FAIL commit_old6 actual=%b required=0000001", seg_l); end
    drive(3'd7, 1'b0, 32'h0);
    checks++;
    if (seg_l !== 7'b0000001 || pending_l !== 1'b1) begin
      errors++; $display("FAIL commit_old7 actual=%b/%b required=0000001/1", seg_l, pending_l);
    end
    drive(3'd0, 1'b0, 32'h0);
    checks++;
    if (pending_l !== 1'b0) begin errors++; $display("FAIL commit_pending actual=%b required=0", pending_l); end
    drive(3'd0, 1'b0, 32'h0);
    checks++;
    if (seg_l !== 7'b0111000) begin errors++; $display("FAIL commit_digit0 actual=%b required=0111000", seg_l); end
    drive(3'd7, 1'b0, 32'h0);
    checks++;
    if (seg_l !== 7'b1000010) begin errors++; $display("FAIL commit_digit7 actual=%b required=1000010", seg_l); end
  endtask

  task automatic test_collision();
    drive(3'd0, 1'b1, 32'h000000A5);
    checks++;
    if (pending_l !== 1'b1 || seg_l !== 7'b0111000) begin
      errors++; $display("FAIL coll_load actual=%b/%b required=1/0111000", pending_l, seg_l);
    end
    drive(3'd1, 1'b0, 32'h0);
    checks++;
    if (pending_l !== 1'b1 || seg_l !== 7'b0110000) begin
      errors++; $display("FAIL coll_old actual=%b/%b required=1/0110000", pending_l, seg_l);
    end
    drive(3'd0, 1'b0, 32'h0);
    checks++;
    if (pending_l !== 1'b0) begin errors++; $display("FAIL coll_commit actual=%b required=0", pending_l); end
    drive(3'd0, 1'b0, 32'h0);
    checks++;
    if (seg_l !== 7'b0100100) begin errors++; $display("FAIL coll_new0 actual=%b required=0100100", seg_l); end
    drive(3'd1, 1'b0, 32'h0);
    checks++;
    if (seg_l !== 7'b0001000) begin errors++; $display("FAIL coll_new1 actual=%b required=0001000", seg_l); end
  endtask

  task automatic test_hold_sel();
    drive(3'd3, 1'b1, 32'h00000100);
    for (int i = 0; i < 3; i++) drive(3'd3, 1'b0, 32'h0);
    checks++;
    if (pending_l !== 1'b1 || seg_l !== 7'b0000001) begin
      errors++; $display("FAIL hold_sel actual=%b/%b required=1/0000001", pending_l, seg_l);
    end
    drive(3'd0, 1'b0, 32'h0);
  endtask

  task automatic test_blanking();
    logic [6:0] exp_a [8];
    exp_a = '{7'b0000001, 7'b0000001, 7'b1001111, 7'b1111111,
              7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    blank_lz = 1'b1;
    for (int s = 7; s >= 0; s--) begin
      drive(3'(s), 1'b0, 32'h0);
      checks++;
      if (seg_l !== exp_a[s] || seg_h !== ~exp_a[s]) begin
        errors++; $display("FAIL blank_100 sel=%0d actual=%b/%b required=%b", s, seg_l, seg_h, exp_a[s]);
      end
    end
    drive(3'd4, 1'b1, 32'h0);
    drive(3'd0, 1'b0, 32'h0);
    for (int s = 7; s >= 0; s--) begin
      drive(3'(s), 1'b0, 32'h0);
      checks++;
      if (seg_l !== ((s == 0) ? 7'b0000001 : 7'b1111111)) begin
        errors++; $display("FAIL blank_zero sel=%0d actual=%b", s, seg_l);
      end
    end
  endtask

  task automatic test_dp();
    dp_en = 8'h04;
    for (int s = 0; s < 8; s++) begin
      drive(3'(s), 1'b0, 32'h0);
      checks++;
      if (seg_l !== ((s == 0) ? 7'b0000001 : 7'b1111111) || dp_l !== (s != 2)) begin
        errors++; $display("FAIL dp_low sel=%0d actual=%b/%b required dp=%b", s, seg_l, dp_l, s != 2);
      end
      checks++;
      if (seg_h !== ((s == 0) ? 7'b1111110 : 7'b0000000) || dp_h !== (s == 2) ||
          anode_out_h !== (8'h01 << s)) begin
        errors++; $display("FAIL dp_high sel=%0d actual=%b/%b/%h", s, seg_h, dp_h, anode_out_h);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    seg_sel  = 3'd0;
    anode_in = 8'hFF;
    data_in  = 32'h0;
    load     = 1'b0;
    dp_en    = 8'h00;
    blank_lz = 1'b0;
    test_reset();
    test_scan_zero();
    test_async_reset();
    test_commit();
    test_collision();
    test_hold_sel();
    test_blanking();
    test_dp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
